// File: rtl/lcd_id_reader.sv
// Reads the panel strap pins off the released LCD RGB bus, debounces them over N_SAMPLES reads and decodes the panel ID.
// Optional feature macro: LCD_ID_RESCAN_EN adds a rescan input that restarts identification from DONE or FAIL.
module lcd_id_reader #(
    parameter int SETTLE_CYC = 1000,
    parameter int N_SAMPLES  = 4,
    parameter int SAMPLE_GAP = 16,
    parameter int MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef LCD_ID_RESCAN_EN
    input  logic        rescan,
`endif
    input  logic [23:0] lcd_rgb_in,
    output logic        lcd_rgb_oe,
    output logic [15:0] lcd_id,
    output logic        id_valid,
    output logic        id_err
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int GW = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
    localparam int NW = $clog2(N_SAMPLES);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        SETTLE = 3'd0,
        SAMPLE = 3'd1,
        DECODE = 3'd2,
        DONE   = 3'd3,
        FAIL   = 3'd4
    } state_t;

    // Returns {known, id}; known=0 for the reserved strap codes.
    function automatic logic [16:0] decode_id(input logic [2:0] code);
        logic [16:0] res;
        case (code)
            3'b000:  res = {1'b1, 16'h4342};
            3'b001:  res = {1'b1, 16'h7084};
            3'b010:  res = {1'b1, 16'h7016};
            3'b100:  res = {1'b1, 16'h4384};
            3'b101:  res = {1'b1, 16'h1018};
            default: res = {1'b0, 16'h0000};
        endcase
        return res;
    endfunction

    state_t         state_r, state_nx;
    logic [SW-1:0]  settle_cnt_r, settle_cnt_nx;
    logic [GW-1:0]  gap_cnt_r, gap_cnt_nx;
    logic [NW-1:0]  smp_cnt_r, smp_cnt_nx;
    logic [2:0]     ref_r, ref_nx;
    logic [RW-1:0]  retry_r, retry_nx;
    logic [15:0]    lcd_id_r, lcd_id_nx;
    logic           id_valid_r, id_err_r, oe_r;
    logic [2:0]     code_s;
    logic [16:0]    dec_s;
    logic           rescan_s;
    logic           unused_s;

    assign code_s   = {lcd_rgb_in[7], lcd_rgb_in[15], lcd_rgb_in[23]};
    assign dec_s    = decode_id(ref_r);
    assign unused_s = ^{lcd_rgb_in[22:16], lcd_rgb_in[14:8], lcd_rgb_in[6:0]};
`ifdef LCD_ID_RESCAN_EN
    assign rescan_s = rescan;
`else
    assign rescan_s = 1'b0;
`endif

    // Next-state and datapath decisions of the identification sequence.
    always_comb begin
        state_nx      = state_r;
        settle_cnt_nx = settle_cnt_r;
        gap_cnt_nx    = gap_cnt_r;
        smp_cnt_nx    = smp_cnt_r;
        ref_nx        = ref_r;
        retry_nx      = retry_r;
        lcd_id_nx     = lcd_id_r;
        case (state_r)
            SETTLE: begin
                if (settle_cnt_r == SW'(SETTLE_CYC - 1)) begin
                    state_nx      = SAMPLE;
                    settle_cnt_nx = {SW{1'b0}};
                    gap_cnt_nx    = {GW{1'b0}};
                    smp_cnt_nx    = {NW{1'b0}};
                end else begin
                    settle_cnt_nx = settle_cnt_r + SW'(1);
                end
            end
            SAMPLE: begin
                gap_cnt_nx = (gap_cnt_r == GW'(SAMPLE_GAP - 1)) ? {GW{1'b0}} : gap_cnt_r + GW'(1);
                if (gap_cnt_r == {GW{1'b0}}) begin
                    if (smp_cnt_r == {NW{1'b0}}) begin
                        ref_nx     = code_s;
                        smp_cnt_nx = NW'(1);
                    end else if (code_s != ref_r) begin
                        // A disagreeing sample aborts this attempt at once.
                        gap_cnt_nx = {GW{1'b0}};
                        smp_cnt_nx = {NW{1'b0}};
                        if (retry_r == RW'(MAX_RETRY)) begin
                            state_nx  = FAIL;
                            lcd_id_nx = 16'h0000;
                        end else begin
                            state_nx      = SETTLE;
                            retry_nx      = retry_r + RW'(1);
                            settle_cnt_nx = {SW{1'b0}};
                        end
                    end else if (smp_cnt_r == NW'(N_SAMPLES - 1)) begin
                        state_nx   = DECODE;
                        gap_cnt_nx = {GW{1'b0}};
                        smp_cnt_nx = {NW{1'b0}};
                    end else begin
                        smp_cnt_nx = smp_cnt_r + NW'(1);
                    end
                end else begin
                    smp_cnt_nx = smp_cnt_r;
                end
            end
            DECODE: begin
                if (dec_s[16]) begin
                    state_nx  = DONE;
                    lcd_id_nx = dec_s[15:0];
                end else begin
                    state_nx  = FAIL;
                    lcd_id_nx = 16'h0000;
                end
            end
            DONE, FAIL: begin
                if (rescan_s) begin
                    state_nx      = SETTLE;
                    retry_nx      = {RW{1'b0}};
                    lcd_id_nx     = 16'h0000;
                    settle_cnt_nx = {SW{1'b0}};
                    gap_cnt_nx    = {GW{1'b0}};
                    smp_cnt_nx    = {NW{1'b0}};
                end else begin
                    state_nx = state_r;
                end
            end
            default: begin
                state_nx      = SETTLE;
                settle_cnt_nx = {SW{1'b0}};
                lcd_id_nx     = 16'h0000;
            end
        endcase
    end

    // State, counters and registered outputs; outputs follow the next state so they change on the entry edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= SETTLE;
            settle_cnt_r <= {SW{1'b0}};
            gap_cnt_r    <= {GW{1'b0}};
            smp_cnt_r    <= {NW{1'b0}};
            ref_r        <= 3'b000;
            retry_r      <= {RW{1'b0}};
            lcd_id_r     <= 16'h0000;
            id_valid_r   <= 1'b0;
            id_err_r     <= 1'b0;
            oe_r         <= 1'b0;
        end else begin
            state_r      <= state_nx;
            settle_cnt_r <= settle_cnt_nx;
            gap_cnt_r    <= gap_cnt_nx;
            smp_cnt_r    <= smp_cnt_nx;
            ref_r        <= ref_nx;
            retry_r      <= retry_nx;
            lcd_id_r     <= lcd_id_nx;
            id_valid_r   <= (state_nx == DONE) || (state_nx == FAIL);
            id_err_r     <= (state_nx == FAIL);
            oe_r         <= (state_nx == DONE) || (state_nx == FAIL);
        end
    end

    assign lcd_id     = lcd_id_r;
    assign id_valid   = id_valid_r;
    assign id_err     = id_err_r;
    assign lcd_rgb_oe = oe_r;

endmodule

// File: tb/tb_lcd_id_reader.sv
// Self-checking bench for lcd_id_reader: a timeline model of the strap-reading rules predicts every output each cycle.
module tb_lcd_id_reader;
    localparam int SETTLE = 1000;
    localparam int NS     = 4;
    localparam int GAP    = 16;
    localparam int MR     = 3;
    localparam int MAXC   = 6000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] rgb = 24'h000000;
    logic        lcd_rgb_oe, id_valid, id_err;
    logic [15:0] lcd_id;
`ifdef LCD_ID_RESCAN_EN
    logic        rescan = 1'b0;
`endif

    lcd_id_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef LCD_ID_RESCAN_EN
        .rescan     (rescan),
`endif
        .lcd_rgb_in (rgb),
        .lcd_rgb_oe (lcd_rgb_oe),
        .lcd_id     (lcd_id),
        .id_valid   (id_valid),
        .id_err     (id_err)
    );

    always #10 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    logic [2:0]  stim [0:MAXC];
    int          end_edge;
    logic [15:0] exp_id;
    logic        exp_err;
    logic        checking = 1'b0;
    int          rise_cyc = -1;
    int          n_checks = 0;
    int          n_err = 0;

    function automatic logic [23:0] make_rgb(input logic [2:0] c);
        logic [23:0] r;
        r = 24'h6A3C55;
        r[23] = c[0];
        r[15] = c[1];
        r[7]  = c[2];
        return r;
    endfunction

    function automatic logic [16:0] panel_id(input logic [2:0] c);
        logic [16:0] r;
        case (c)
            3'b000:  r = {1'b1, 16'h4342};
            3'b001:  r = {1'b1, 16'h7084};
            3'b010:  r = {1'b1, 16'h7016};
            3'b100:  r = {1'b1, 16'h4384};
            3'b101:  r = {1'b1, 16'h1018};
            default: r = {1'b0, 16'h0000};
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Fill the strap table with base, glitching the sample at index kidx on the first nglitch attempts.
    task automatic build(input logic [2:0] base, input int nglitch, input int kidx, input logic [2:0] mask);
        int a, tp, tk;
        for (int t = 0; t <= MAXC; t++) stim[t] = base;
        a = 0;
        for (int g = 0; g < nglitch; g++) begin
            tp = a + SETTLE + 1 + (kidx - 1) * GAP;
            tk = tp + GAP;
            for (int t = tp + 1; t <= tk; t++) stim[t] = base ^ mask;
            a = tk;
        end
    endtask

    // Walk the attempts from start edge a0: sample times, agreement, retries, final ID.
    task automatic compute_expect(input int a0);
        int a, retry, t;
        logic [2:0] refc;
        logic fin, abort;
        logic [16:0] d;
        a = a0; retry = 0; fin = 1'b0; refc = 3'b000;
        while (!fin) begin
            abort = 1'b0;
            for (int k = 0; k < NS; k++) begin
                t = a + SETTLE + 1 + k * GAP;
                if (t > MAXC) begin
                    end_edge = MAXC + 1; exp_id = 16'h0000; exp_err = 1'b1; fin = 1'b1; abort = 1'b1;
                    break;
                end
                if (k == 0) refc = stim[t];
                else if (stim[t] != refc) begin
                    abort = 1'b1;
                    if (retry == MR) begin
                        end_edge = t; exp_id = 16'h0000; exp_err = 1'b1; fin = 1'b1;
                    end else begin
                        retry++; a = t;
                    end
                    break;
                end
            end
            if (!abort) begin
                d = panel_id(refc);
                end_edge = t + 1;
                exp_id = d[16] ? d[15:0] : 16'h0000;
                exp_err = !d[16];
                fin = 1'b1;
            end
        end
    endtask

    // Single compare process: every cycle with reset released, outputs must match the model.
    initial begin
        logic prev_v, ev;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (checking && rst_n) begin
                ev = (cyc >= end_edge);
                n_checks++;
                if ({id_valid, id_err, lcd_rgb_oe, lcd_id} !== {ev, ev & exp_err, ev, ev ? exp_id : 16'h0000}) begin
                    n_err++;
                    $display("FAIL cycle_model cyc=%0d: got v=%b e=%b oe=%b id=%h want v=%b e=%b oe=%b id=%h",
                             cyc, id_valid, id_err, lcd_rgb_oe, lcd_id, ev, ev & exp_err, ev, ev ? exp_id : 16'h0000);
                end
                if (id_valid && !prev_v && rise_cyc < 0) rise_cyc = cyc;
            end
            prev_v = id_valid;
        end
    end

    task automatic do_reset(input int hold);
        checking = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", {15'd0, id_valid, id_err, lcd_rgb_oe, lcd_id}, 32'h0);
        repeat (hold) @(negedge clk);
        rise_cyc = -1;
        rgb = make_rgb(stim[1]);
        rst_n = 1'b1;
        checking = 1'b1;
    endtask

    task automatic run_to(input int last);
        int guard;
        guard = 0;
        while (cyc < last && guard < MAXC) begin
            @(negedge clk);
            guard++;
            rgb = make_rgb(stim[(cyc + 1 <= MAXC) ? cyc + 1 : MAXC]);
`ifdef LCD_ID_RESCAN_EN
            rescan = (cyc == 500 || cyc == 1010);
`endif
        end
        if (cyc < last) chk("run_timeout", cyc, last);
    endtask

    initial begin
        // Straps 001: ID 7084, valid on cycle 1050.
        build(3'b001, 0, 1, 3'b001); compute_expect(0);
        do_reset(3); run_to(1060);
        chk("s001_rise", rise_cyc, 1050);
        chk("s001_id", lcd_id, 32'h7084);
        chk("s001_err_oe", {id_err, lcd_rgb_oe}, 32'h1);
        // Straps 101 then reserved 111.
        build(3'b101, 0, 1, 3'b001); compute_expect(0);
        do_reset(3); run_to(1060);
        chk("s101_id", lcd_id, 32'h1018);
        build(3'b111, 0, 1, 3'b001); compute_expect(0);
        do_reset(3); run_to(1060);
        chk("s111_rise", rise_cyc, 1050);
        chk("s111_out", {id_valid, id_err, lcd_id}, 32'h30000);
        // M0 toggled before the second sample on all four attempts.
        build(3'b000, 4, 1, 3'b001); compute_expect(0);
        do_reset(3); run_to(4080);
        chk("retry_fail_rise", rise_cyc, 4068);
        chk("retry_fail_err", {id_valid, id_err, lcd_id}, 32'h30000);
        // Only the first attempt glitched.
        build(3'b000, 1, 1, 3'b001); compute_expect(0);
        do_reset(3); run_to(2080);
        chk("retry1_rise", rise_cyc, 2067);
        chk("retry1_id", {id_err, lcd_id}, 32'h4342);
        // M1 glitch on the last sample of the first attempt.
        build(3'b010, 1, 3, 3'b010); compute_expect(0);
        do_reset(3); run_to(2110);
        chk("late_glitch_rise", rise_cyc, 2099);
        chk("late_glitch_id", lcd_id, 32'h7016);
        // Reset pulled mid-SAMPLE, then a clean run.
        build(3'b100, 0, 1, 3'b001); compute_expect(0);
        do_reset(3); run_to(1020);
        do_reset(3); run_to(1060);
        chk("midreset_rise", rise_cyc, 1050);
        chk("midreset_id", lcd_id, 32'h4384);
`ifdef LCD_ID_RESCAN_EN
        begin
            int r;
            build(3'b010, 0, 1, 3'b001); compute_expect(0);
            do_reset(3); run_to(1060);
            chk("pre_rescan_id", lcd_id, 32'h7016);
            checking = 1'b0;
            @(negedge clk);
            rescan = 1'b1;
            r = cyc + 1;
            for (int t = r + 1; t <= MAXC; t++) stim[t] = 3'b100;
            rgb = make_rgb(3'b100);
            @(negedge clk);
            rescan = 1'b0;
            chk("rescan_drop", {id_valid, id_err, lcd_rgb_oe, lcd_id}, 32'h0);
            compute_expect(r);
            rise_cyc = -1;
            checking = 1'b1;
            run_to(r + 1060);
            chk("rescan_rise", rise_cyc, r + 1050);
            chk("rescan_id", lcd_id, 32'h4384);
        end
`endif
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
